// File: rtl/mcu_spi_pkg.sv
// mcu_spi_pkg: shared constants for the MCU SPI target mux.
// Target ids for the known core controllers and the counter widths.
package mcu_spi_pkg;

    localparam logic [7:0] TGT_SYS    = 8'd0;
    localparam logic [7:0] TGT_HID    = 8'd1;
    localparam logic [7:0] TGT_OSD    = 8'd2;
    localparam logic [7:0] TGT_SDC    = 8'd3;
    localparam logic [7:0] TGT_STATUS = 8'hFF;

    localparam int BIT_CNT_W  = 3;
    localparam int BYTE_CNT_W = 4;

endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: brings the asynchronous SPI pins into the clk domain.
// sclk additionally gets single-cycle rise/fall pulses from a previous-value
// flop; ss and din are only synchronised. ss resets to "deasserted".
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic ss_pin,
    input  logic sclk_pin,
    input  logic din_pin,
    output logic ss,
    output logic din,
    output logic sclk_rise,
    output logic sclk_fall
);

    logic [SYNC_STAGES-1:0] ss_sr;
    logic [SYNC_STAGES-1:0] sclk_sr;
    logic [SYNC_STAGES-1:0] din_sr;
    logic                   sclk_prev;

    // synchroniser chains plus last synced sclk for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            ss_sr     <= '1;
            sclk_sr   <= '0;
            din_sr    <= '0;
            sclk_prev <= 1'b0;
        end else begin
            ss_sr     <= {ss_sr[SYNC_STAGES-2:0], ss_pin};
            sclk_sr   <= {sclk_sr[SYNC_STAGES-2:0], sclk_pin};
            din_sr    <= {din_sr[SYNC_STAGES-2:0], din_pin};
            sclk_prev <= sclk_sr[SYNC_STAGES-1];
        end
    end

    assign ss        = ss_sr[SYNC_STAGES-1];
    assign din       = din_sr[SYNC_STAGES-1];
    assign sclk_rise =  sclk_sr[SYNC_STAGES-1] & ~sclk_prev;
    assign sclk_fall = ~sclk_sr[SYNC_STAGES-1] &  sclk_prev;

endmodule

// File: rtl/mcu_spi_mux.sv
// mcu_spi_mux: oversampled SPI slave that routes MCU payload bytes to
// NUM_TARGETS core targets. Byte 0 of a transaction selects the target,
// later bytes are strobed to it and its mcu_din slice is shifted out on MISO.
// Optional: define MCU_SPI_STATUS_EN to answer target 8'hFF internally with
// a dropped-byte counter.
module mcu_spi_mux
    import mcu_spi_pkg::*;
#(
    parameter int NUM_TARGETS = 4,
    parameter int SYNC_STAGES = 2,
    parameter int SAMPLE_FALL = 1,
    parameter int START_CNT   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     spi_io_ss,
    input  logic                     spi_io_clk,
    input  logic                     spi_io_din,
    output logic                     spi_io_dout,
    output logic [NUM_TARGETS-1:0]   mcu_strobe,
    output logic                     mcu_start,
    output logic [7:0]               mcu_target,
    output logic                     mcu_busy,
    input  logic [8*NUM_TARGETS-1:0] mcu_din,
    output logic [7:0]               mcu_dout
);

    localparam logic [BYTE_CNT_W-1:0] START_V = BYTE_CNT_W'(START_CNT);

    logic                  ss_s, din_s, sclk_rise, sclk_fall, ss_prev;
    logic                  sample_edge, setup_edge, ss_assert, pay_done;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic [BYTE_CNT_W-1:0] byte_cnt;
    logic [6:0]            shreg;
    logic [7:0]            rx_byte, tx, rd_byte;
    logic [1:0]            vld_pipe;
    logic [NUM_TARGETS-1:0] tgt_hit;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .reset     (reset),
        .ss_pin    (spi_io_ss),
        .sclk_pin  (spi_io_clk),
        .din_pin   (spi_io_din),
        .ss        (ss_s),
        .din       (din_s),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall)
    );

    assign sample_edge = (SAMPLE_FALL != 0) ? sclk_fall : sclk_rise;
    assign setup_edge  = (SAMPLE_FALL != 0) ? sclk_rise : sclk_fall;
    assign ss_assert   = ss_prev & ~ss_s;
    assign rx_byte     = {shreg, din_s};
    // ss has priority: a sample edge coinciding with deselect is ignored
    assign pay_done    = sample_edge & ~ss_s & (bit_cnt == 3'd7) & (byte_cnt != '0);

    // per-target decode of the latched id; ids >= NUM_TARGETS hit nothing
    for (genvar t = 0; t < NUM_TARGETS; t++) begin : g_tgt
        assign tgt_hit[t] = (mcu_target == 8'(t));
    end

    // strobe fires one clk after mcu_dout updates
    assign mcu_strobe = vld_pipe[1] ? tgt_hit : '0;
    assign mcu_busy   = ~ss_s;
    assign spi_io_dout = tx[7];

`ifdef MCU_SPI_STATUS_EN
    logic [3:0] drop_cnt;

    // count payload bytes lost to unknown targets; any write to status clears
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt <= 4'h0;
        end else if (pay_done) begin
            if (mcu_target == TGT_STATUS)
                drop_cnt <= 4'h0;
            else if (~|tgt_hit && drop_cnt != 4'hF)
                drop_cnt <= drop_cnt + 4'h1;
        end
    end
`endif

    // readback byte for the current target; byte 0 and unknown ids read zero
    always_comb begin
        rd_byte = 8'h00;
        if (byte_cnt != '0) begin
            for (int t = 0; t < NUM_TARGETS; t++)
                if (tgt_hit[t]) rd_byte = mcu_din[8*t +: 8];
`ifdef MCU_SPI_STATUS_EN
            if (mcu_target == TGT_STATUS)
                rd_byte = {drop_cnt != 4'h0, 3'b000, drop_cnt};
`endif
        end
    end

    // receive path, counters, tx shifter and strobe/start timing
    always_ff @(posedge clk) begin
        if (reset) begin
            ss_prev    <= 1'b1;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            shreg      <= '0;
            tx         <= '0;
            mcu_target <= '0;
            mcu_dout   <= '0;
            mcu_start  <= 1'b0;
            vld_pipe   <= '0;
        end else begin
            ss_prev   <= ss_s;
            vld_pipe  <= {vld_pipe[0], pay_done};
            mcu_start <= ~ss_s & (byte_cnt == START_V);

            if (ss_s) begin
                bit_cnt  <= '0;
                byte_cnt <= '0;
            end else if (sample_edge) begin
                bit_cnt <= bit_cnt + 1'b1;
                shreg   <= rx_byte[6:0];
                if (bit_cnt == 3'd7) begin
                    if (byte_cnt == '0) mcu_target <= rx_byte;
                    else                mcu_dout   <= rx_byte;
                    if (byte_cnt != '1) byte_cnt <= byte_cnt + 1'b1;
                end
            end

            // bit 0 is presented at select (mode 0) or at its setup edge (mode 1)
            if (ss_assert || (setup_edge && ~ss_s && bit_cnt == '0))
                tx <= rd_byte;
            else if (setup_edge && ~ss_s)
                tx <= {tx[6:0], 1'b0};
        end
    end

endmodule

// File: tb/tb_mcu_spi_mux.sv
// tb_mcu_spi_mux: mode-1 SPI master driving table vectors plus abort,
// status and mid-byte reset sequences against mcu_spi_mux (4 targets).
module tb_mcu_spi_mux;
    import mcu_spi_pkg::*;

    localparam int NT   = 4;
    localparam int HALF = 4;

`ifdef MCU_SPI_STATUS_EN
    localparam logic [7:0] ST_CLR = 8'h81;
    localparam logic [7:0] ST_RD  = 8'h83;
`else
    localparam logic [7:0] ST_CLR = 8'h00;
    localparam logic [7:0] ST_RD  = 8'h00;
`endif

    logic            clk = 1'b0, reset = 1'b1, ss = 1'b1, sclk = 1'b0, mosi = 1'b0;
    logic            miso, start, busy;
    logic [NT-1:0]   strobe;
    logic [7:0]      target, dout;
    logic [8*NT-1:0] din = 32'h44_22_5A_33;
    int              checks = 0, errors = 0;

    // mo/mi: byte b at [b]; stb/np: expected strobe pattern and pulse count
    typedef struct {
        logic [3:0][7:0] mo;
        int              n;
        logic [3:0][7:0] mi;
        logic [NT-1:0]   stb;
        int              np;
        logic [7:0]      dout0;
        logic            start0;
        logic [7:0]      doutl;
        logic [7:0]      tgt;
    } vec_t;

    typedef struct packed {
        logic [NT-1:0] stb;
        logic [7:0]    dout;
        logic          start;
    } pulse_t;

    vec_t   vt [10];
    pulse_t pq [$];

    mcu_spi_mux #(.NUM_TARGETS(NT), .SYNC_STAGES(2), .SAMPLE_FALL(1), .START_CNT(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .spi_io_ss   (ss),
        .spi_io_clk  (sclk),
        .spi_io_din  (mosi),
        .spi_io_dout (miso),
        .mcu_strobe  (strobe),
        .mcu_start   (start),
        .mcu_target  (target),
        .mcu_busy    (busy),
        .mcu_din     (din),
        .mcu_dout    (dout)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (strobe != '0) pq.push_back({strobe, dout, start});

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // mode 1: set up MOSI on sclk rise, sample MISO just before sclk fall
    task automatic spi_byte(input logic [7:0] tb, input int nbits, output logic [7:0] rb);
        rb = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            @(negedge clk);
            sclk = 1'b1;
            mosi = tb[i];
            clks(HALF);
            rb[i] = miso;
            sclk = 1'b0;
            clks(HALF);
        end
    endtask

    task automatic run_vec(input int idx);
        vec_t       v;
        logic [7:0] r;
        v = vt[idx];
        pq.delete();
        ss = 1'b0;
        clks(4);
        chk($sformatf("v%0d busy_active", idx), busy, 1);
        for (int b = 0; b < v.n; b++) begin
            spi_byte(v.mo[b], 8, r);
            chk($sformatf("v%0d miso_byte%0d", idx, b), r, v.mi[b]);
        end
        clks(6);
        ss = 1'b1;
        clks(6);
        chk($sformatf("v%0d busy_idle", idx), busy, 0);
        chk($sformatf("v%0d start_idle", idx), start, 0);
        chk($sformatf("v%0d target", idx), target, v.tgt);
        chk($sformatf("v%0d pulses", idx), pq.size(), v.np);
        if (v.np > 0 && pq.size() == v.np) begin
            foreach (pq[k]) chk($sformatf("v%0d strobe%0d", idx, k), pq[k].stb, v.stb);
            chk($sformatf("v%0d dout_first", idx), pq[0].dout, v.dout0);
            chk($sformatf("v%0d start_first", idx), pq[0].start, v.start0);
            chk($sformatf("v%0d dout_last", idx), pq[pq.size()-1].dout, v.doutl);
        end
    endtask

    initial begin
        logic [7:0] r;

        vt[0] = '{mo:32'h00_3C_A5_02, n:3, mi:32'h00_22_22_00, stb:4'b0100, np:2,
                  dout0:8'hA5, start0:1'b1, doutl:8'h3C, tgt:TGT_OSD};
        vt[1] = '{mo:32'h00_00_00_01, n:2, mi:32'h00_00_5A_00, stb:4'b0010, np:1,
                  dout0:8'h00, start0:1'b1, doutl:8'h00, tgt:TGT_HID};
        vt[2] = '{mo:32'h00_00_99_07, n:2, mi:32'h0, stb:4'b0000, np:0,
                  dout0:8'h00, start0:1'b0, doutl:8'h00, tgt:8'h07};
        vt[3] = '{mo:32'h00_81_C3_03, n:3, mi:32'h00_44_44_00, stb:4'b1000, np:2,
                  dout0:8'hC3, start0:1'b1, doutl:8'h81, tgt:TGT_SDC};
        vt[4] = '{mo:32'h00_00_11_00, n:2, mi:32'h00_00_33_00, stb:4'b0001, np:1,
                  dout0:8'h11, start0:1'b1, doutl:8'h11, tgt:TGT_SYS};
        vt[5] = '{mo:{16'h0, 8'h00, TGT_STATUS}, n:2, mi:{16'h0, ST_CLR, 8'h00}, stb:4'b0000, np:0,
                  dout0:8'h00, start0:1'b0, doutl:8'h00, tgt:TGT_STATUS};
        vt[6] = '{mo:32'h03_02_01_07, n:4, mi:32'h0, stb:4'b0000, np:0,
                  dout0:8'h00, start0:1'b0, doutl:8'h00, tgt:8'h07};
        vt[7] = '{mo:{16'h0, 8'h00, TGT_STATUS}, n:2, mi:{16'h0, ST_RD, 8'h00}, stb:4'b0000, np:0,
                  dout0:8'h00, start0:1'b0, doutl:8'h00, tgt:TGT_STATUS};
        vt[8] = '{mo:{16'h0, 8'h00, TGT_STATUS}, n:2, mi:32'h0, stb:4'b0000, np:0,
                  dout0:8'h00, start0:1'b0, doutl:8'h00, tgt:TGT_STATUS};
        vt[9] = '{mo:32'h00_00_5A_02, n:2, mi:32'h00_00_22_00, stb:4'b0100, np:1,
                  dout0:8'h5A, start0:1'b1, doutl:8'h5A, tgt:TGT_OSD};

        // reset state
        clks(3);
        reset = 1'b0;
        chk("rst strobe", strobe, 0);
        chk("rst start", start, 0);
        chk("rst target", target, 0);
        chk("rst busy", busy, 0);
        chk("rst dout", dout, 0);
        chk("rst miso", miso, 0);
        clks(4);

        for (int i = 0; i < 4; i++) run_vec(i);

        // abort: ss raised after 5 bits of the second byte
        pq.delete();
        ss = 1'b0;
        clks(4);
        spi_byte(8'h01, 8, r);
        spi_byte(8'hFF, 5, r);
        clks(2);
        ss = 1'b1;
        clks(8);
        chk("abort pulses", pq.size(), 0);
        chk("abort start", start, 0);
        chk("abort busy", busy, 0);

        for (int i = 4; i < 9; i++) run_vec(i);

        // reset mid-byte, with a payload byte already landed
        ss = 1'b0;
        clks(4);
        spi_byte(8'h02, 8, r);
        spi_byte(8'hA7, 8, r);
        clks(4);
        chk("pre_reset start", start, 1);
        chk("pre_reset dout", dout, 8'hA7);
        spi_byte(8'hF0, 4, r);
        reset = 1'b1;
        clks(1);
        reset = 1'b0;
        chk("midrst strobe", strobe, 0);
        chk("midrst start", start, 0);
        chk("midrst target", target, 0);
        chk("midrst busy", busy, 0);
        chk("midrst dout", dout, 0);
        chk("midrst miso", miso, 0);
        clks(4);
        ss = 1'b1;
        clks(6);
        run_vec(9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
